// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor; one SEG_W-bit segment per stage.
// Upper operand bits and resolved lower sum bits ride along in per-stage skew registers.
module csel_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int NSEG = WIDTH / SEG_W;

    if (WIDTH % SEG_W != 0) begin : g_bad_param
        $error("csel_adder_pipe: WIDTH %0d not a multiple of SEG_W %0d",
               WIDTH, SEG_W);
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_a0;
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // Bubbles load zeros so unknown operands never enter the pipe.
    assign w_a0 = in_valid ? in_a : '0;
    assign w_b0 = in_valid ? (in_sub ? ~in_b : in_b) : '0;
    assign w_c0 = in_valid & (in_sub | in_cin);

    for (genvar k = 0; k < NSEG; k++) begin : g_st
        localparam int R  = WIDTH - k * SEG_W;
        localparam int LO = (k + 1) * SEG_W;

        logic [R-1:0]   w_ra;
        logic [R-1:0]   w_rb;
        logic           w_ci;
        logic           w_vi;
        logic [SEG_W:0] w_s0;
        logic [SEG_W:0] w_s1;
        logic [SEG_W:0] w_sel;
        logic [LO-1:0]  w_nsum;

        if (k == 0) begin : g_src
            assign w_ra   = w_a0;
            assign w_rb   = w_b0;
            assign w_ci   = w_c0;
            assign w_vi   = in_valid;
            assign w_nsum = w_sel[SEG_W-1:0];
        end else begin : g_src
            assign w_ra   = g_st[k-1].g_fw.r_a;
            assign w_rb   = g_st[k-1].g_fw.r_b;
            assign w_ci   = g_st[k-1].g_fw.r_c;
            assign w_vi   = g_st[k-1].g_fw.r_v;
            assign w_nsum = {w_sel[SEG_W-1:0], g_st[k-1].g_fw.r_s};
        end

        assign w_s0  = {1'b0, w_ra[SEG_W-1:0]} + {1'b0, w_rb[SEG_W-1:0]};
        assign w_s1  = {1'b0, w_ra[SEG_W-1:0]} + {1'b0, w_rb[SEG_W-1:0]}
                     + (SEG_W + 1)'(1);
        assign w_sel = w_ci ? w_s1 : w_s0;

        if (k < NSEG - 1) begin : g_fw
            logic [R-SEG_W-1:0] r_a;
            logic [R-SEG_W-1:0] r_b;
            logic [LO-1:0]      r_s;
            logic               r_c;
            logic               r_v;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_a <= '0;
                    r_b <= '0;
                    r_s <= '0;
                    r_c <= 1'b0;
                    r_v <= 1'b0;
                end else if (w_adv) begin
                    r_a <= w_ra[R-1:SEG_W];
                    r_b <= w_rb[R-1:SEG_W];
                    r_s <= w_nsum;
                    r_c <= w_sel[SEG_W];
                    r_v <= w_vi;
                end
            end
        end else begin : g_out
            // MSB-sign form of (carry into MSB) ^ (carry out of MSB).
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    out_valid <= 1'b0;
                    out_sum   <= '0;
                    out_cout  <= 1'b0;
                    out_ovf   <= 1'b0;
                    out_zero  <= 1'b0;
                end else if (w_adv) begin
                    out_valid <= w_vi;
                    out_sum   <= w_nsum;
                    out_cout  <= w_sel[SEG_W];
                    out_ovf   <= (w_ra[SEG_W-1] ~^ w_rb[SEG_W-1])
                               & (w_sel[SEG_W-1] ^ w_ra[SEG_W-1]);
                    out_zero  <= (w_nsum == '0);
                end
            end
        end
    end

endmodule
